cfg_chain_ctrl: RTL and testbench

Bus-mapped controller for an external serial configuration chain of parametrised length. Software fills a word-addressed shadow buffer, issues START, and the block serialises the buffer MSB-first on sout/sclk, capturing sin into the same buffer so the old chain contents can be read back. It then pulses latch. Successor to the single-bit-per-access shift register; sits behind the user-area memory-mapped bus.

---
 rtl/cfg_chain_pkg.sv | 28 ++
 rtl/cfg_chain_clkdiv.sv | 39 +++
 rtl/cfg_chain_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the serial configuration chain controller.
// Holds the register map, the STATUS/CTRL field positions and the
// sequencer state encoding.
package cfg_chain_pkg;

    // Word addresses on the user-area bus
    localparam logic [7:0] ADDR_CTRL   = 8'd0;
    localparam logic [7:0] ADDR_STATUS = 8'd1;
    localparam logic [7:0] ADDR_DATA0  = 8'd2;

    // CTRL fields
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_IRQEN_BIT = 1;

    // STATUS fields
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_CNT_LSB   = 16;
    localparam int CNT_W          = 11;   // holds up to 1024 bits remaining

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

endpackage

// File: rtl/cfg_chain_clkdiv.sv
// Half-period timer for the chain sequencer.
// Counts clk cycles within the current phase and flags its first and
// last cycle. The count restarts whenever the sequencer changes state
// and is held at zero while the sequencer is idle.
//   clk, reset : system clock, synchronous active-high reset
//   en_i       : sequencer is in an active phase
//   clr_i      : sequencer enters a new state at the next edge
//   tick_o     : last cycle of the current phase
//   first_o    : first cycle of the current phase
module cfg_chain_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic first_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o  = en_i && (cnt_q == LAST);
    assign first_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Bus-mapped controller for an external serial configuration chain.
// Software fills a word-addressed shadow buffer and writes START; the
// buffer is shifted out MSB-first on sout/sclk while sin is captured
// into the vacated LSB, so the old chain contents end up in the buffer.
// A latch strobe follows the last bit.
//   Bus   : valid/ready (one-cycle ack), we, wstrb, addr (word), wdata, rdata
//   Chain : sclk, sout, sin, latch
//   Misc  : busy, irq
// Map: 0 CTRL, 1 STATUS {cnt[26:16], done[1], busy[0]}, 2.. DATA words.
// Optional macro CFG_CHAIN_IRQ_EN: adds CTRL bit1 (irq enable) and drives
// irq from done; without it irq is tied low.
module cfg_chain_ctrl
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 164,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [3:0]  wstrb_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        sclk_o,
    output logic        sout_o,
    input  logic        sin_i,
    output logic        latch_o,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int NWORDS = (CHAIN_LEN + 31) / 32;
    localparam int NB     = NWORDS * 32;
    // Bits above the chain length are held at zero in the buffer
    localparam logic [NB-1:0] MASK = {NB{1'b1}} >> (NB - CHAIN_LEN);

    state_e            state_q, state_d;
    logic [NB-1:0]     shbuf_q, shbuf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              sout_q, sout_d;
    logic              sin_q, sin_d;
    logic              ready_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              tick, first;
    logic              acc, wr, ctrl_wr, start, stat_clr;
    logic              sin_bit;
    logic [NB-1:0]     shifted;

    assign acc      = valid_i && !ready_q;
    assign wr       = acc && we_i;
    assign ctrl_wr  = wr && (addr_i == ADDR_CTRL) && wstrb_i[0];
    assign start    = ctrl_wr && wdata_i[CTRL_START_BIT] && (state_q == IDLE);
    assign stat_clr = wr && (addr_i == ADDR_STATUS) && wstrb_i[0]
                      && wdata_i[STAT_DONE_BIT];

    // With CLK_DIV=1 the sampling cycle is also the shift cycle, so the
    // live input is used instead of the stored sample.
    assign sin_bit  = first ? sin_i : sin_q;
    assign shifted  = ((shbuf_q << 1) | NB'(sin_bit)) & MASK;

    cfg_chain_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q != IDLE),
        .clr_i   (state_d != state_q),
        .tick_o  (tick),
        .first_o (first)
    );

`ifdef CFG_CHAIN_IRQ_EN
    logic irq_en_q, irq_en_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = wdata_i[CTRL_IRQEN_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset) irq_en_q <= 1'b0;
        else       irq_en_q <= irq_en_d;
    end

    assign irq_o = irq_en_q && done_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shbuf_d = shbuf_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        sout_d  = sout_q;
        sin_d   = sin_q;
        // Clear first so a completion in the same cycle overrides it
        if (stat_clr) done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT_LO;
                    cnt_d   = CNT_W'(CHAIN_LEN);
                    sout_d  = shbuf_q[CHAIN_LEN-1];
                    done_d  = 1'b0;
                end else if (wr) begin
                    for (int w = 0; w < NWORDS; w++) begin
                        if (addr_i == 8'(ADDR_DATA0 + w)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wstrb_i[b]) shbuf_d[w*32+b*8 +: 8] = wdata_i[b*8 +: 8];
                            end
                        end
                    end
                    shbuf_d = shbuf_d & MASK;
                end
            end
            SHIFT_LO: begin
                if (tick) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (first) sin_d = sin_i;
                if (tick) begin
                    shbuf_d = shifted;
                    cnt_d   = cnt_q - 1'b1;
                    sout_d  = shifted[CHAIN_LEN-1];
                    state_d = (cnt_q == CNT_W'(1)) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux; DATA reads during a shift return the partly rotated buffer
    always_comb begin
        rdata_d = '0;
        if (acc && !we_i) begin
            if (addr_i == ADDR_CTRL) begin
`ifdef CFG_CHAIN_IRQ_EN
                rdata_d[CTRL_IRQEN_BIT] = irq_en_q;
`endif
            end else if (addr_i == ADDR_STATUS) begin
                rdata_d[STAT_BUSY_BIT]             = (state_q != IDLE);
                rdata_d[STAT_DONE_BIT]             = done_q;
                rdata_d[STAT_CNT_LSB +: CNT_W]     = cnt_q;
            end else begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (addr_i == 8'(ADDR_DATA0 + w)) rdata_d = shbuf_q[w*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shbuf_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sout_q  <= 1'b0;
            sin_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            shbuf_q <= shbuf_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sout_q  <= sout_d;
            sin_q   <= sin_d;
            ready_q <= acc;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;
    assign sclk_o  = (state_q == SHIFT_HI);
    assign latch_o = (state_q == LATCH);
    assign busy_o  = (state_q != IDLE);
    assign sout_o  = sout_q;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Directed bench for cfg_chain_ctrl. Instance 0: CHAIN_LEN=8, CLK_DIV=1,
// looped through an 8-bit external chain model. Instance 1: CHAIN_LEN=40,
// CLK_DIV=2, used for byte-strobe and masking checks.
module tb_cfg_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid [2];
    logic        we    [2];
    logic [3:0]  wstrb [2];
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        sclk  [2];
    logic        sout  [2];
    logic        sin   [2];
    logic        latch [2];
    logic        busy  [2];
    logic        irq   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // External chain: shifts on the sclk rising phase, after the DUT has
    // seen the current sin for that bit.
    logic [7:0] model, mval;
    logic       mload, sclk_d;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        sclk_d <= sclk[0];
        if (mload) model <= mval;
        else if (sclk[0] && !sclk_d) model <= {model[6:0], sout[0]};
    end
    assign sin[0] = model[7];
    assign sin[1] = 1'b0;

    cfg_chain_ctrl #(.CHAIN_LEN(8), .CLK_DIV(1)) u8 (
        .clk(clk), .reset(reset), .valid_i(valid[0]), .ready_o(ready[0]),
        .we_i(we[0]), .wstrb_i(wstrb[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .sclk_o(sclk[0]), .sout_o(sout[0]), .sin_i(sin[0]),
        .latch_o(latch[0]), .busy_o(busy[0]), .irq_o(irq[0])
    );

    cfg_chain_ctrl #(.CHAIN_LEN(40), .CLK_DIV(2)) u40 (
        .clk(clk), .reset(reset), .valid_i(valid[1]), .ready_o(ready[1]),
        .we_i(we[1]), .wstrb_i(wstrb[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .sclk_o(sclk[1]), .sout_o(sout[1]), .sin_i(sin[1]),
        .latch_o(latch[1]), .busy_o(busy[1]), .irq_o(irq[1])
    );

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // edge on which the access was performed (ready high).
    task automatic bus(input int s, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] st,
                       output logic [31:0] rd);
        int n;
        valid[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d; wstrb[s] = st;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready[s] && n < 8);
        if (!ready[s]) begin
            checks++; failures++;
            $display("FAIL bus_ack inst=%0d addr=%0d got ready=0 exp ready=1", s, a);
        end
        rd = rdata[s];
        valid[s] = 1'b0; we[s] = 1'b0;
    endtask

    task automatic wr(input int s, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] st);
        logic [31:0] dummy;
        bus(s, 1'b1, a, d, st, dummy);
    endtask

    task automatic rd(input int s, input logic [7:0] a, output logic [31:0] d);
        bus(s, 1'b0, a, 32'h0, 4'h0, d);
    endtask

    task automatic preload(input logic [7:0] v);
        mval = v; mload = 1'b1;
        @(posedge clk); #1;
        mload = 1'b0;
    endtask

    // Edges from the START access edge until busy falls (bounded)
    task automatic wait_idle(input int t0, output int el);
        int n;
        n = 0;
        while (busy[0] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (busy[0]) begin
            checks++; failures++;
            $display("FAIL wait_idle timeout got busy=1 exp busy=0");
        end
        el = cyc - t0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({ready[s], rdata[s], sclk[s], sout[s], latch[s], busy[s], irq[s]} !== 38'h0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", s,
                         {ready[s], rdata[s], sclk[s], sout[s], latch[s], busy[s], irq[s]});
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        rd(0, 8'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", d); end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        wr(1, 8'd2, 32'hFFFF_FFFF, 4'b0010);
        rd(1, 8'd2, d);
        checks++; if (d !== 32'h0000_FF00) begin failures++; $display("FAIL wstrb_data0 got=%h exp=0000ff00", d); end
        @(posedge clk); #1;
        checks++; if (ready[1] !== 1'b0) begin failures++; $display("FAIL ready_pulse got=%b exp=0", ready[1]); end
        // word 1 holds chain bits 32..39 only
        wr(1, 8'd3, 32'hFFFF_FFFF, 4'b1111);
        rd(1, 8'd3, d);
        checks++; if (d !== 32'h0000_00FF) begin failures++; $display("FAIL mask_data1 got=%h exp=000000ff", d); end
        wr(1, 8'd3, 32'h0, 4'b1111);
        wr(1, 8'd3, 32'hFFFF_FFFF, 4'b0010);
        rd(1, 8'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mask_data1_b1 got=%h exp=0", d); end
        wr(1, 8'h80, 32'hFFFF_FFFF, 4'hF);
        rd(1, 8'h80, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", d); end
        rd(1, 8'd4, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL past_data got=%h exp=0", d); end
        rd(1, 8'd0, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_read got=%h exp=0", d); end
    endtask

    task automatic test_shift();
        logic [31:0] d;
        logic [7:0]  so;
        logic        prev;
        int          nb, lc, done_at, t0;
        wr(0, 8'd2, 32'h0000_00A5, 4'hF);
        rd(0, 8'd2, d);
        checks++; if (d !== 32'h0000_00A5) begin failures++; $display("FAIL data0_wr got=%h exp=a5", d); end
        preload(8'h3C);
        wr(0, 8'd0, 32'h1, 4'h1);
        t0 = cyc; so = '0; nb = 0; lc = 0; done_at = -1; prev = sclk[0];
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sclk[0] && !prev) begin so = {so[6:0], sout[0]}; nb++; end
            prev = sclk[0];
            if (latch[0]) lc++;
            if (!busy[0]) begin done_at = cyc - t0; break; end
        end
        checks++; if (so !== 8'hA5 || nb != 8) begin failures++; $display("FAIL sout_seq got=%h n=%0d exp=a5 n=8", so, nb); end
        checks++; if (lc != 1) begin failures++; $display("FAIL latch_len got=%0d exp=1", lc); end
        // START cycle is cycle 0; done shows in cycle 18, 17 edges later
        checks++; if (done_at != 17) begin failures++; $display("FAIL done_time got=%0d exp=17", done_at); end
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL status_done got=%h exp=2", d); end
        rd(0, 8'd2, d);
        checks++; if (d !== 32'h0000_003C) begin failures++; $display("FAIL readback got=%h exp=3c", d); end
        checks++; if (model !== 8'hA5) begin failures++; $display("FAIL chain_model got=%h exp=a5", model); end
    endtask

    task automatic test_busy();
        logic [31:0] d, s1, s2;
        int t0, el;
        wr(0, 8'd2, 32'h0000_005A, 4'hF);
        preload(8'hC3);
        wr(0, 8'd0, 32'h1, 4'h1);
        t0 = cyc;
        wr(0, 8'd0, 32'h1, 4'h1);           // ignored restart
        rd(0, 8'd1, s1);
        wr(0, 8'd2, 32'h0000_00FF, 4'hF);   // ignored data write
        rd(0, 8'd1, s2);
        checks++; if (s1 !== 32'h0007_0001) begin failures++; $display("FAIL busy_status1 got=%h exp=00070001", s1); end
        checks++; if (s2 !== 32'h0005_0001) begin failures++; $display("FAIL busy_status2 got=%h exp=00050001", s2); end
        wait_idle(t0, el);
        checks++; if (el != 17) begin failures++; $display("FAIL no_restart got=%0d exp=17", el); end
        rd(0, 8'd2, d);
        checks++; if (d !== 32'h0000_00C3) begin failures++; $display("FAIL busy_readback got=%h exp=c3", d); end
        checks++; if (model !== 8'h5A) begin failures++; $display("FAIL busy_model got=%h exp=5a", model); end
    endtask

    task automatic test_done_race();
        logic [31:0] d;
        wr(0, 8'd0, 32'h1, 4'h1);
        repeat (16) @(posedge clk);
        #1;
        checks++; if (latch[0] !== 1'b1) begin failures++; $display("FAIL race_latch got=%b exp=1", latch[0]); end
        wr(0, 8'd1, 32'h2, 4'h1);           // performed in the LATCH cycle
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL race_done got=%h exp=2", d); end
        wr(0, 8'd1, 32'h2, 4'h1);
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL done_clear got=%h exp=0", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int t0, el, bad;
        bad = 0;
`ifdef CFG_CHAIN_IRQ_EN
        wr(0, 8'd0, 32'h2, 4'h1);
        rd(0, 8'd0, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL irq_en_rd got=%h exp=2", d); end
        wr(0, 8'd0, 32'h3, 4'h1);
        t0 = cyc;
        while (busy[0] && (cyc - t0) < 200) begin
            if (irq[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        el = cyc - t0;
        checks++; if (bad != 0 || el != 17) begin failures++; $display("FAIL irq_busy got=%0d/%0d exp=0/17", bad, el); end
        checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq[0]); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (irq[0] !== 1'b1) begin failures++; $display("FAIL irq_sticky got=%b exp=1", irq[0]); end
        wr(0, 8'd1, 32'h2, 4'h1);
        checks++; if (irq[0] !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq[0]); end
`else
        wr(0, 8'd0, 32'h2, 4'h1);
        rd(0, 8'd0, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_b1_rd got=%h exp=0", d); end
        wr(0, 8'd0, 32'h3, 4'h1);
        t0 = cyc;
        while (busy[0] && (cyc - t0) < 200) begin
            if (irq[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        el = cyc - t0;
        repeat (3) begin
            if (irq[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0 || el != 17) begin failures++; $display("FAIL irq_tied got=%0d/%0d exp=0/17", bad, el); end
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL noirq_done got=%h exp=2", d); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lc;
        wr(0, 8'd2, 32'h0000_00FF, 4'hF);
        wr(0, 8'd0, 32'h1, 4'h1);
        repeat (8) @(posedge clk);          // four bits done, count=4
        #1;
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy[0]); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready[0], rdata[0], sclk[0], sout[0], latch[0], busy[0], irq[0]} !== 38'h0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0",
                     {ready[0], rdata[0], sclk[0], sout[0], latch[0], busy[0], irq[0]});
        end
        lc = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (latch[0] !== 1'b0) lc++;
        end
        checks++; if (lc != 0) begin failures++; $display("FAIL mid_latch got=%0d exp=0", lc); end
        rd(0, 8'd1, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_status got=%h exp=0", d); end
        rd(0, 8'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_data0 got=%h exp=0", d); end
    endtask

    initial begin
        reset = 1'b1; mload = 1'b0; mval = 8'h0;
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; we[s] = 1'b0; wstrb[s] = 4'h0; addr[s] = 8'h0; wdata[s] = 32'h0;
        end
        test_reset();
        test_wstrb();
        test_shift();
        test_busy();
        test_done_race();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
